count_arbiter: RTL and testbench

Sequencer and arbiter that shares one two-channel event counter (Slt/En/Reset interface, counter 0 and counter 1) between two requesters. Each requester asks for a burst of Len count events. The block grants one requester at a time in round-robin order, then drives En/Slt for exactly that many enabled cycles, with optional stalls. It signals completion back to the owner. It sits directly upstream of the counter and is the only driver of its Slt and En inputs.

---
 rtl/count_arb_pkg.sv | 18 +
 rtl/count_arbiter_if.sv | 41 ++++
 rtl/rr_pick2.sv | 21 ++
 rtl/count_arbiter.sv | 104 ++++++++++
 tb/tb_count_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/count_arb_pkg.sv
// -----------------------------------------------------------------------------
// count_arb_pkg
// Holds the items shared by the count_arbiter slice:
//   - state_e    : the FSM state encoding (IDLE, GRANT, RUN, DONE)
//   - LEN_W_DEFAULT : the default burst-length width
// -----------------------------------------------------------------------------
package count_arb_pkg;

  localparam int LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : count_arb_pkg

// File: rtl/count_arbiter_if.sv
// -----------------------------------------------------------------------------
// count_arbiter_if
// Groups the requester handshake and the counter-facing outputs of
// count_arbiter.
//   req0/req1   : level requests, held until the matching grant
//   len0/len1   : burst lengths, sampled when the request is accepted
//   hold        : stall, no count event while high during RUN
//   gnt0/gnt1   : one-cycle grant pulses
//   done0/done1 : one-cycle completion pulses
//   busy        : arbiter not idle
//   slt/en      : select and enable driven into the shared event counter
// Modports: master = requester/system side, slave = the arbiter.
// -----------------------------------------------------------------------------
interface count_arbiter_if #(
  parameter int LEN_W = count_arb_pkg::LEN_W_DEFAULT
);

  logic             req0;
  logic             req1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             hold;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             busy;
  logic             slt;
  logic             en;

  modport master (
    output req0, req1, len0, len1, hold,
    input  gnt0, gnt1, done0, done1, busy, slt, en
  );

  modport slave (
    input  req0, req1, len0, len1, hold,
    output gnt0, gnt1, done0, done1, busy, slt, en
  );

endinterface : count_arbiter_if

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin pick, purely combinational.
//   req[1:0] : pending requests
//   ptr      : channel favoured when both request
//   valid    : at least one request is pending
//   winner   : chosen channel (meaningful only when valid)
// -----------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       winner
);

  assign valid = |req;

  // A lone request wins outright; the pointer only breaks a tie.
  assign winner = (req == 2'b11) ? ptr : req[1];

endmodule : rr_pick2

// File: rtl/count_arbiter.sv
// -----------------------------------------------------------------------------
// count_arbiter
// Shares one two-channel event counter between two requesters. A winner is
// picked in round-robin order, granted for one cycle, then En/Slt are driven
// for exactly Len enabled cycles (Hold stalls), and a Done pulse closes the
// burst. The counter's own Reset is left to the system.
//   clk  : rising-edge clock shared with the counter
//   rst  : asynchronous active-high reset
//   bus  : count_arbiter_if slave modport (requests, lengths, hold,
//          grants, dones, busy, slt, en)
// -----------------------------------------------------------------------------
module count_arbiter
  import count_arb_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  count_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q,   ptr_d;
  logic [LEN_W-1:0] rem_q,   rem_d;

  logic pick_valid;
  logic pick_winner;

  rr_pick2 u_pick (
    .req    ({bus.req1, bus.req0}),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // NOTE: every control register is reset so all outputs, which decode from
  // them, drop the moment rst rises; non-blocking assignments keep the
  // register updates order-independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  // NOTE: every value written here is defaulted first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          rem_d   = pick_winner ? bus.len1 : bus.len0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        state_d = (rem_q == '0) ? ST_DONE : ST_RUN;
      end

      ST_RUN: begin
        // rem_q is at least 1 here, so the decrement cannot wrap.
        if (!bus.hold) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        ptr_d   = ~owner_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: registered state/owner only, except En which follows Hold.
  assign bus.gnt0  = (state_q == ST_GRANT) && !owner_q;
  assign bus.gnt1  = (state_q == ST_GRANT) &&  owner_q;
  assign bus.done0 = (state_q == ST_DONE)  && !owner_q;
  assign bus.done1 = (state_q == ST_DONE)  &&  owner_q;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.slt   = (state_q == ST_RUN)   &&  owner_q;
  assign bus.en    = (state_q == ST_RUN)   && !bus.hold;

endmodule : count_arbiter

// File: tb/tb_count_arbiter.sv
// -----------------------------------------------------------------------------
// tb_count_arbiter
// Directed bench for count_arbiter. Each scenario records every output over a
// window of cycles into a bit-per-cycle vector (bit k = cycle k, cycle 0 being
// the IDLE cycle in which the request is first seen) and compares the vector
// with a hand-computed constant. A small counter model tallies En pulses per
// Slt value to stand in for the attached event counter.
// -----------------------------------------------------------------------------
module tb_count_arbiter;
  import count_arb_pkg::*;

  logic clk;
  logic rst;

  count_arbiter_if #(.LEN_W(LEN_W_DEFAULT)) bus ();

  count_arbiter #(.LEN_W(LEN_W_DEFAULT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Stand-in for the shared counter: one event per clock with En high.
  int cnt0 = 0;
  int cnt1 = 0;
  always @(posedge clk) begin
    if (bus.en) begin
      if (bus.slt) cnt1 <= cnt1 + 1;
      else         cnt0 <= cnt0 + 1;
    end
  end

  logic [31:0] tr_gnt0, tr_gnt1, tr_done0, tr_done1, tr_busy, tr_slt, tr_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the n-th rising edge from now.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Records n cycles, applying hold_vec[k] in cycle k. With auto_drop a
  // requester lowers Req (and scrambles Len) in the cycle after its grant.
  task automatic trace(input int n, input bit auto_drop, input logic [31:0] hold_vec);
    tr_gnt0 = '0; tr_gnt1 = '0; tr_done0 = '0; tr_done1 = '0;
    tr_busy = '0; tr_slt  = '0; tr_en    = '0;
    for (int k = 0; k < n; k++) begin
      bus.hold = hold_vec[k];
      @(negedge clk);
      tr_gnt0[k]  = bus.gnt0;
      tr_gnt1[k]  = bus.gnt1;
      tr_done0[k] = bus.done0;
      tr_done1[k] = bus.done1;
      tr_busy[k]  = bus.busy;
      tr_slt[k]   = bus.slt;
      tr_en[k]    = bus.en;
      step(1);
      if (auto_drop && tr_gnt0[k]) begin
        bus.req0 = 1'b0;
        bus.len0 = '1;
      end
      if (auto_drop && tr_gnt1[k]) begin
        bus.req1 = 1'b0;
        bus.len1 = '1;
      end
    end
    bus.hold = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},  {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    check({tag, "_done"}, {30'd0, bus.done1, bus.done0}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_slt"},  {31'd0, bus.slt}, 32'd0);
    check({tag, "_en"},   {31'd0, bus.en}, 32'd0);
  endtask

  int c0, c1;

  initial begin
    rst      = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.len0 = '0;
    bus.len1 = '0;
    bus.hold = 1'b0;

    // Reset state, then a quiet stretch with no requests.
    step(2);
    check_outputs_zero("reset");
    rst = 1'b0;
    trace(20, 1'b0, 32'd0);
    check("idle_busy", tr_busy, 32'd0);
    check("idle_en",   tr_en,   32'd0);

    // Single request on channel 1, Len = 4 (leaves ptr = 0).
    c0 = cnt0; c1 = cnt1;
    bus.req1 = 1'b1;
    bus.len1 = 8'd4;
    trace(10, 1'b1, 32'd0);
    check("single_gnt1",  tr_gnt1,  32'h0000_0002);
    check("single_gnt0",  tr_gnt0,  32'h0000_0000);
    check("single_en",    tr_en,    32'h0000_003C);
    check("single_slt",   tr_slt,   32'h0000_003C);
    check("single_done1", tr_done1, 32'h0000_0040);
    check("single_done0", tr_done0, 32'h0000_0000);
    check("single_busy",  tr_busy,  32'h0000_007E);
    check("single_cnt1",  32'(cnt1 - c1), 32'd4);
    check("single_cnt0",  32'(cnt0 - c0), 32'd0);

    // Contention: both held, Len = 2 each; grants alternate 0,1,0,1.
    c0 = cnt0; c1 = cnt1;
    bus.req0 = 1'b1; bus.len0 = 8'd2;
    bus.req1 = 1'b1; bus.len1 = 8'd2;
    trace(20, 1'b0, 32'd0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("cont_gnt0",  tr_gnt0,  32'h0000_0802);
    check("cont_gnt1",  tr_gnt1,  32'h0001_0040);
    check("cont_done0", tr_done0, 32'h0000_4010);
    check("cont_done1", tr_done1, 32'h0008_0200);
    check("cont_en",    tr_en,    32'h0006_318C);
    check("cont_slt",   tr_slt,   32'h0006_0180);
    check("cont_busy",  tr_busy,  32'h000F_7BDE);
    check("cont_cnt0",  32'(cnt0 - c0), 32'd4);
    check("cont_cnt1",  32'(cnt1 - c1), 32'd4);
    step(2);

    // Zero-length burst on channel 0.
    c0 = cnt0;
    bus.req0 = 1'b1;
    bus.len0 = 8'd0;
    trace(5, 1'b1, 32'd0);
    check("zero_gnt0",  tr_gnt0,  32'h0000_0002);
    check("zero_done0", tr_done0, 32'h0000_0004);
    check("zero_en",    tr_en,    32'h0000_0000);
    check("zero_busy",  tr_busy,  32'h0000_0006);
    check("zero_cnt0",  32'(cnt0 - c0), 32'd0);
    step(2);

    // Stall: Len = 3 on channel 0, Hold high in cycles 3 and 4.
    c0 = cnt0;
    bus.req0 = 1'b1;
    bus.len0 = 8'd3;
    trace(10, 1'b1, 32'h0000_0018);
    check("stall_gnt0",  tr_gnt0,  32'h0000_0002);
    check("stall_en",    tr_en,    32'h0000_0064);
    check("stall_slt",   tr_slt,   32'h0000_0000);
    check("stall_done0", tr_done0, 32'h0000_0080);
    check("stall_busy",  tr_busy,  32'h0000_00FE);
    check("stall_cnt0",  32'(cnt0 - c0), 32'd3);
    step(2);

    // Abort: channel 1 Len = 5, reset mid-cycle while the third En is up.
    c1 = cnt1;
    bus.req1 = 1'b1;
    bus.len1 = 8'd5;
    trace(4, 1'b1, 32'd0);
    check("abort_pre_en", tr_en, 32'h0000_000C);
    check("abort_live_en", {31'd0, bus.en}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("abort_async");
    step(1);
    rst = 1'b0;
    check("abort_cnt1", 32'(cnt1 - c1), 32'd2);
    trace(10, 1'b0, 32'd0);
    check("abort_no_done1", tr_done1, 32'd0);
    check("abort_quiet",    tr_busy,  32'd0);

    // After the abort ptr is back at 0: channel 0 wins the tie.
    bus.req0 = 1'b1; bus.len0 = 8'd1;
    bus.req1 = 1'b1; bus.len1 = 8'd1;
    trace(3, 1'b1, 32'd0);
    check("post_gnt0", tr_gnt0, 32'h0000_0002);
    check("post_gnt1", tr_gnt1, 32'h0000_0000);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_count_arbiter
